// File: rtl/ldq_violation_detect_pkg.sv
// Shared LSQ types and helpers: LDQ pointer with wrap bit, age from head, younger-than-store mask.
// Purely combinational; no latency or backpressure.
package ldq_violation_detect_pkg;

  localparam int LDQ_DEPTH = 16;
  localparam int LDQ_INDEX = 4;
  localparam int LDQ_WIDTH = 8;

  typedef logic [LDQ_INDEX:0]   ldq_ptr_t;
  typedef logic [LDQ_INDEX-1:0] ldq_idx_t;
  typedef logic [LDQ_DEPTH-1:0] ldq_vec_t;

  // Offset from head; truncation to INDEX bits gives the mod-DEPTH wrap.
  function automatic ldq_idx_t ldq_age(input ldq_idx_t idx, input ldq_idx_t head);
    return ldq_idx_t'(idx - head);
  endfunction

  // Entries in [start, tail) circularly; the wrap bits let a full queue (n == DEPTH) differ from empty.
  function automatic ldq_vec_t younger_mask(input ldq_ptr_t start, input ldq_ptr_t tail);
    ldq_ptr_t n;
    ldq_idx_t off;
    ldq_vec_t m;
    n = ldq_ptr_t'(tail - start);
    m = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      off  = ldq_idx_t'(i) - start[LDQ_INDEX-1:0];
      m[i] = ({1'b0, off} < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/ldq_violation_detect_if.sv
// Store pipe, LDQ state, CAM search and recovery handshake signals of the violation detector.
// slave is the detector's view, master the view of the surrounding pipeline.
interface ldq_violation_detect_if;
  import ldq_violation_detect_pkg::*;

  logic                 recover_i;
  logic                 st_valid_i;
  logic [LDQ_WIDTH-1:0] st_addr_i;
  ldq_ptr_t             st_ldq_idx_i;
  ldq_idx_t             ldq_head_i;
  ldq_ptr_t             ldq_tail_i;
  logic                 ld_exec_i;
  ldq_idx_t             ld_exec_idx_i;
  logic                 ld_commit_i;
  logic [LDQ_WIDTH-1:0] cam_tag_o;
  ldq_vec_t             cam_vect_i;
  logic                 viol_valid_o;
  ldq_idx_t             viol_idx_o;
  logic                 viol_ack_i;

  modport slave (
    input  recover_i, st_valid_i, st_addr_i, st_ldq_idx_i, ldq_head_i, ldq_tail_i,
           ld_exec_i, ld_exec_idx_i, ld_commit_i, cam_vect_i, viol_ack_i,
    output cam_tag_o, viol_valid_o, viol_idx_o
  );

  modport master (
    output recover_i, st_valid_i, st_addr_i, st_ldq_idx_i, ldq_head_i, ldq_tail_i,
           ld_exec_i, ld_exec_idx_i, ld_commit_i, cam_vect_i, viol_ack_i,
    input  cam_tag_o, viol_valid_o, viol_idx_o
  );

endinterface

// File: rtl/ldq_violation_detect_circ_prio_sel.sv
// Circular priority encoder: first set bit of vec at or above start, wrapping DEPTH-1 to 0.
// Combinational, no backpressure; DEPTH must be 2**INDEX.
module ldq_circ_prio_sel #(
  parameter int DEPTH = 16,
  parameter int INDEX = 4
) (
  input  logic [DEPTH-1:0] vec,
  input  logic [INDEX-1:0] start,
  output logic             found,
  output logic [INDEX-1:0] idx
);

  logic [INDEX-1:0] pos;

  // Scan from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      pos = start + INDEX'(k);
      if (vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/ldq_violation_detect.sv
// Store-side LDQ CAM search flagging the oldest executed younger load that matches a store address.
// Store to violation in 2 cycles, one search per cycle, no backpressure; violation held until acked.
module ldq_violation_detect
  import ldq_violation_detect_pkg::*;
#(
  parameter int DEPTH = LDQ_DEPTH,
  parameter int INDEX = LDQ_INDEX,
  parameter int WIDTH = LDQ_WIDTH
) (
  input logic                   clk,
  input logic                   reset,
  ldq_violation_detect_if.slave ldq
);

  logic             s0_valid;
  logic [WIDTH-1:0] s0_addr;
  ldq_ptr_t         s0_ldq_idx;
  logic [DEPTH-1:0] exec_vec;
  logic [DEPTH-1:0] exec_nxt;
  logic [DEPTH-1:0] cand;
  logic             sel_found;
  logic [INDEX-1:0] sel_idx;
  logic             s1_hit;
  logic             sel_older;
  logic             viol_valid;
  logic [INDEX-1:0] viol_idx;
  logic             st_accept;

  assign st_accept = ldq.st_valid_i && !ldq.recover_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid   <= 1'b0;
      s0_addr    <= '0;
      s0_ldq_idx <= '0;
    end else begin
      s0_valid <= st_accept;
      if (st_accept) begin
        s0_addr    <= ldq.st_addr_i;
        s0_ldq_idx <= ldq.st_ldq_idx_i;
      end
    end
  end

  // The tag register only moves on an accepted store, so it holds between searches.
  assign ldq.cam_tag_o = s0_addr;

  assign cand = ldq.cam_vect_i & exec_vec & younger_mask(s0_ldq_idx, ldq.ldq_tail_i);

  ldq_circ_prio_sel #(
    .DEPTH (DEPTH),
    .INDEX (INDEX)
  ) u_sel (
    .vec   (cand),
    .start (s0_ldq_idx[INDEX-1:0]),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign s1_hit    = s0_valid && sel_found;
  assign sel_older = ldq_age(sel_idx, ldq.ldq_head_i) < ldq_age(viol_idx, ldq.ldq_head_i);

  // Commit clears first so an execute to the same slot in the same cycle wins.
  always_comb begin
    exec_nxt = exec_vec;
    if (ldq.ld_commit_i) exec_nxt[ldq.ldq_head_i] = 1'b0;
    if (ldq.ld_exec_i)   exec_nxt[ldq.ld_exec_idx_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || ldq.recover_i) begin
      exec_vec <= '0;
    end else begin
      exec_vec <= exec_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      viol_valid <= 1'b0;
      viol_idx   <= '0;
    end else if (ldq.recover_i) begin
      viol_valid <= 1'b0;
    end else if (s1_hit && (!viol_valid || ldq.viol_ack_i || sel_older)) begin
      viol_valid <= 1'b1;
      viol_idx   <= sel_idx;
    end else if (ldq.viol_ack_i) begin
      viol_valid <= 1'b0;
    end
  end

  assign ldq.viol_valid_o = viol_valid;
  assign ldq.viol_idx_o   = viol_idx;

endmodule

// File: tb/tb_ldq_violation_detect.sv
// Directed scenarios plus randomized traffic against a queue-level model of the violation detector.
module tb_ldq_violation_detect;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  ldq_violation_detect_if bus ();

  ldq_violation_detect dut (
    .clk   (clk),
    .reset (reset),
    .ldq   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: set of executed loads, the in-flight store, and the held violation.
  bit [15:0] m_exec;
  bit        m_s0v;
  bit [4:0]  m_s0ptr;
  bit [7:0]  m_tag;
  bit        m_vv;
  bit [3:0]  m_vidx;
  bit        model_live;
  int        m_n;
  int        m_pos;
  int        m_found;
  int        m_fidx;
  int        m_age_new;
  int        m_age_old;

  initial begin
    model_live = 1'b0;
    m_exec = '0; m_s0v = 1'b0; m_s0ptr = '0; m_tag = '0; m_vv = 1'b0; m_vidx = '0;
  end

  always @(posedge clk) begin
    m_found = 0;
    m_fidx  = 0;
    if (m_s0v) begin
      m_n = (int'(bus.ldq_tail_i) - int'(m_s0ptr) + 32) % 32;
      for (int d = 0; d < m_n; d++) begin
        m_pos = (int'(m_s0ptr) + d) % 16;
        if (m_found == 0 && bus.cam_vect_i[m_pos] && m_exec[m_pos]) begin
          m_found = 1;
          m_fidx  = m_pos;
        end
      end
    end
    if (reset) begin
      m_exec = '0; m_s0v = 1'b0; m_s0ptr = '0; m_tag = '0; m_vv = 1'b0; m_vidx = '0;
      model_live = 1'b1;
    end else if (bus.recover_i) begin
      m_exec = '0;
      m_s0v  = 1'b0;
      m_vv   = 1'b0;
    end else begin
      if (m_found != 0) begin
        m_age_new = (m_fidx - int'(bus.ldq_head_i) + 16) % 16;
        m_age_old = (int'(m_vidx) - int'(bus.ldq_head_i) + 16) % 16;
        if (!m_vv || bus.viol_ack_i || m_age_new < m_age_old) begin
          m_vv   = 1'b1;
          m_vidx = 4'(m_fidx);
        end else if (bus.viol_ack_i) begin
          m_vv = 1'b0;
        end
      end else if (bus.viol_ack_i) begin
        m_vv = 1'b0;
      end
      if (bus.ld_commit_i) m_exec[bus.ldq_head_i] = 1'b0;
      if (bus.ld_exec_i)   m_exec[bus.ld_exec_idx_i] = 1'b1;
      m_s0v = bus.st_valid_i;
      if (bus.st_valid_i) begin
        m_s0ptr = bus.st_ldq_idx_i;
        m_tag   = bus.st_addr_i;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("cam_tag", 32'(bus.cam_tag_o), 32'(m_tag));
      check("viol_valid", 32'(bus.viol_valid_o), 32'(m_vv));
      check("viol_idx", 32'(bus.viol_idx_o), 32'(m_vidx));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    reset              = 1'b0;
    bus.recover_i      = 1'b0;
    bus.st_valid_i     = 1'b0;
    bus.ld_exec_i      = 1'b0;
    bus.ld_commit_i    = 1'b0;
    bus.viol_ack_i     = 1'b0;
    bus.cam_vect_i     = '0;
  endtask

  task automatic exec_ld(input int idx);
    idle();
    bus.ld_exec_i     = 1'b1;
    bus.ld_exec_idx_i = 4'(idx);
    tick();
    bus.ld_exec_i = 1'b0;
  endtask

  task automatic flush();
    idle();
    bus.recover_i = 1'b1;
    tick();
    bus.recover_i = 1'b0;
  endtask

  task automatic ack();
    idle();
    bus.viol_ack_i = 1'b1;
    tick();
    bus.viol_ack_i = 1'b0;
  endtask

  // Store at T, CAM vector at T+1; returns at the negedge where the result is visible.
  task automatic search(input int start, input int tail, input logic [15:0] cam);
    idle();
    bus.st_valid_i   = 1'b1;
    bus.st_addr_i    = 8'($urandom);
    bus.st_ldq_idx_i = 5'(start);
    bus.ldq_tail_i   = 5'(tail);
    tick();
    bus.st_valid_i = 1'b0;
    bus.cam_vect_i = cam;
    tick();
    bus.cam_vect_i = '0;
  endtask

  logic [4:0] prev_ptr;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    reset             = 1'b1;
    bus.st_addr_i     = '0;
    bus.st_ldq_idx_i  = '0;
    bus.ldq_head_i    = '0;
    bus.ldq_tail_i    = '0;
    bus.ld_exec_idx_i = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_cam_tag", 32'(bus.cam_tag_o), 32'h0);
    check("reset_viol_valid", 32'(bus.viol_valid_o), 32'h0);
    check("reset_viol_idx", 32'(bus.viol_idx_o), 32'h0);

    // Basic violation
    bus.ldq_head_i = 4'd0;
    exec_ld(5);
    exec_ld(7);
    idle();
    bus.st_valid_i   = 1'b1;
    bus.st_addr_i    = 8'h3A;
    bus.st_ldq_idx_i = 5'd4;
    bus.ldq_tail_i   = 5'd10;
    tick();
    bus.st_valid_i = 1'b0;
    bus.cam_vect_i = 16'h00A0;
    check("basic_cam_tag", 32'(bus.cam_tag_o), 32'h3A);
    tick();
    bus.cam_vect_i = '0;
    check("basic_valid", 32'(bus.viol_valid_o), 32'h1);
    check("basic_idx", 32'(bus.viol_idx_o), 32'd5);

    // Wrap-around
    flush();
    bus.ldq_head_i = 4'd12;
    exec_ld(15);
    exec_ld(1);
    exec_ld(13);
    search(14, 19, 16'h8002);
    check("wrap_valid", 32'(bus.viol_valid_o), 32'h1);
    check("wrap_idx", 32'(bus.viol_idx_o), 32'd15);
    ack();
    check("wrap_ack_valid", 32'(bus.viol_valid_o), 32'h0);
    search(14, 19, 16'h2000);
    check("wrap_older_valid", 32'(bus.viol_valid_o), 32'h0);

    // Empty and full ranges
    flush();
    bus.ldq_head_i = 4'd0;
    exec_ld(1);
    search(6, 6, 16'hFFFF);
    check("empty_valid", 32'(bus.viol_valid_o), 32'h0);
    search(2, 18, 16'h0002);
    check("full_valid", 32'(bus.viol_valid_o), 32'h1);
    check("full_idx", 32'(bus.viol_idx_o), 32'd1);

    // Hold and replace
    flush();
    bus.ldq_head_i = 4'd0;
    exec_ld(6);
    exec_ld(9);
    exec_ld(11);
    search(8, 16, 16'h0200);
    check("hold_first_idx", 32'(bus.viol_idx_o), 32'd9);
    search(5, 16, 16'h0040);
    check("hold_replace_idx", 32'(bus.viol_idx_o), 32'd6);
    search(10, 16, 16'h0800);
    check("hold_keep_valid", 32'(bus.viol_valid_o), 32'h1);
    check("hold_keep_idx", 32'(bus.viol_idx_o), 32'd6);
    ack();
    check("hold_ack_valid", 32'(bus.viol_valid_o), 32'h0);

    // Unexecuted, committed, and same-cycle-executed loads are filtered
    flush();
    bus.ldq_head_i = 4'd0;
    search(0, 8, 16'h0008);
    check("unexec_valid", 32'(bus.viol_valid_o), 32'h0);
    exec_ld(2);
    idle();
    bus.ldq_head_i  = 4'd2;
    bus.ld_commit_i = 1'b1;
    tick();
    bus.ld_commit_i = 1'b0;
    bus.ldq_head_i  = 4'd0;
    search(0, 8, 16'h0004);
    check("committed_valid", 32'(bus.viol_valid_o), 32'h0);
    idle();
    bus.st_valid_i   = 1'b1;
    bus.st_ldq_idx_i = 5'd0;
    bus.ldq_tail_i   = 5'd8;
    tick();
    bus.st_valid_i    = 1'b0;
    bus.cam_vect_i    = 16'h0010;
    bus.ld_exec_i     = 1'b1;
    bus.ld_exec_idx_i = 4'd4;
    tick();
    idle();
    check("same_cycle_exec_valid", 32'(bus.viol_valid_o), 32'h0);

    // Recover and reset mid-flight
    flush();
    exec_ld(5);
    idle();
    bus.st_valid_i   = 1'b1;
    bus.st_addr_i    = 8'h55;
    bus.st_ldq_idx_i = 5'd4;
    bus.ldq_tail_i   = 5'd10;
    tick();
    bus.st_valid_i = 1'b0;
    bus.recover_i  = 1'b1;
    bus.cam_vect_i = 16'h0020;
    tick();
    idle();
    check("recover_valid", 32'(bus.viol_valid_o), 32'h0);
    check("recover_exec_vec", 32'(dut.exec_vec), 32'h0);
    check("recover_idx_held", 32'(bus.viol_idx_o), 32'd6);
    exec_ld(5);
    idle();
    bus.st_valid_i   = 1'b1;
    bus.st_addr_i    = 8'hC3;
    bus.st_ldq_idx_i = 5'd4;
    tick();
    bus.st_valid_i = 1'b0;
    reset          = 1'b1;
    bus.cam_vect_i = 16'h0020;
    tick();
    idle();
    check("midreset_cam_tag", 32'(bus.cam_tag_o), 32'h0);
    check("midreset_valid", 32'(bus.viol_valid_o), 32'h0);
    check("midreset_idx", 32'(bus.viol_idx_o), 32'h0);

    // Randomized traffic; tail keeps the in-flight store's range within the queue depth.
    prev_ptr = bus.st_ldq_idx_i;
    for (int c = 0; c < 3000; c++) begin
      reset             = ($urandom_range(0, 299) == 0);
      bus.recover_i     = ($urandom_range(0, 49) == 0);
      bus.st_valid_i    = ($urandom_range(0, 9) < 7);
      bus.st_addr_i     = 8'($urandom);
      bus.st_ldq_idx_i  = 5'($urandom);
      bus.ldq_head_i    = 4'($urandom);
      bus.ldq_tail_i    = prev_ptr + 5'($urandom_range(0, 16));
      bus.ld_exec_i     = ($urandom_range(0, 1) == 0);
      bus.ld_exec_idx_i = 4'($urandom);
      bus.ld_commit_i   = ($urandom_range(0, 3) == 0);
      bus.cam_vect_i    = 16'($urandom | $urandom);
      bus.viol_ack_i    = ($urandom_range(0, 3) == 0);
      prev_ptr          = bus.st_ldq_idx_i;
      tick();
    end
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
